// File: rtl/seg_dyn_scan.sv
// seg_dyn_scan: converts a 20-bit binary value to six BCD digits with a
// sequential double-dabble engine and time-multiplexes them onto a 6-digit
// common-anode 7-segment display (sel/seg feed the 74HC595 shift driver).
//
// Conversion FSM
//   state | meaning
//   IDLE  | wait for new data (or pending first conversion), then capture
//   SHIFT | 20 double-dabble steps: add-3 on nibbles >= 5, shift left by 1
//   DONE  | copy the accumulator into the display register in one cycle
module seg_dyn_scan #(
    parameter logic [15:0] CNT_MAX = 16'd49_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [19:0] data_last;
    logic [19:0] bin;
    logic [23:0] acc;
    logic [23:0] acc_adj;
    logic [23:0] disp_bcd;
    logic        pending;
    logic [4:0]  shift_cnt;
    logic        start;

    logic [15:0] scan_cnt;
    logic [2:0]  idx;
    logic [2:0]  msd;
    logic [3:0]  nib;
    logic [7:0]  seg_nxt;

    assign start = (data != data_last) || pending;

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    // Conversion FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Conversion FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == 5'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 6; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Double-dabble datapath; shift_cnt is a down-counter for the 20 steps
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_last <= '0;
            bin       <= '0;
            acc       <= '0;
            disp_bcd  <= '0;
            pending   <= 1'b1;
            shift_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin       <= (data > 20'd999_999) ? 20'd999_999 : data;
                        data_last <= data;
                        pending   <= 1'b0;
                        acc       <= '0;
                        shift_cnt <= 5'd19;
                    end
                end
                SHIFT: begin
                    {acc, bin} <= {acc_adj[22:0], bin, 1'b0};
                    shift_cnt  <= shift_cnt - 5'd1;
                end
                DONE:    disp_bcd <= acc;
                default: ;
            endcase
        end
    end

    // Digit dwell counter and digit index; free-running even when disabled
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CNT_MAX) begin
            scan_cnt <= '0;
            idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    // Most significant shown digit: highest nonzero digit or highest point bit
    always_comb begin
        msd = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if ((disp_bcd[4*i +: 4] != 4'd0) || point[i]) msd = 3'(i);
        end
    end

    // Segment pattern for the current digit: number, minus or blank, plus dp
    always_comb begin
        nib = disp_bcd[{idx, 2'b00} +: 4];
        if (idx <= msd)
            seg_nxt = seg_code(nib);
        else if (sign && (msd != 3'd5) && (idx == msd + 3'd1))
            seg_nxt = 8'hBF;
        else
            seg_nxt = 8'hFF;
        if (point[idx]) seg_nxt[7] = 1'b0;
    end

    // Registered display outputs; blanked one cycle after seg_en drops
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel <= '0;
            seg <= 8'hFF;
        end else if (!seg_en) begin
            sel <= '0;
            seg <= 8'hFF;
        end else begin
            sel <= 6'b000001 << idx;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_dyn_scan.sv
// Testbench for seg_dyn_scan: scoreboard of expected per-digit segment codes
// computed from decimal arithmetic, popped by a monitor whenever the DUT
// selects the matching digit.
module tb_seg_dyn_scan;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         digit;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];

    logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seg_dyn_scan #(.CNT_MAX(16'd3)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data      (data),
        .point     (point),
        .sign      (sign),
        .seg_en    (seg_en),
        .sel       (sel),
        .seg       (seg)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: decimal digits of the clamped value
    function automatic int dec_digit(input logic [19:0] d, input int pos);
        int v;
        v = (d > 20'd999999) ? 999999 : int'(d);
        for (int k = 0; k < pos; k++) v = v / 10;
        return v % 10;
    endfunction

    function automatic logic [23:0] to_bcd(input logic [19:0] d);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r[4*i +: 4] = 4'(dec_digit(d, i));
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input logic [19:0] d, input logic [5:0] p,
                                           input logic s, input int digit);
        int top;
        logic [7:0] c;
        top = 0;
        for (int i = 0; i < 6; i++) if (dec_digit(d, i) != 0 || p[i]) top = i;
        if (digit <= top)                             c = lut[dec_digit(d, digit)];
        else if (s && top < 5 && digit == top + 1)    c = 8'hBF;
        else                                          c = 8'hFF;
        if (p[digit]) c[7] = 1'b0;
        return c;
    endfunction

    // Monitor: compare when the DUT selects the digit at the queue head
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (sb.size() > 0 && seg_en && sel == (6'b000001 << sb[0].digit)) begin
                e = sb.pop_front();
                chk($sformatf("seg_digit%0d", e.digit), {24'd0, seg}, {24'd0, e.seg});
            end
        end
    end

    task automatic wait_sb();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        chk("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic scenario(input logic [19:0] d, input logic [5:0] p, input logic s);
        exp_t e;
        @(negedge sys_clk);
        data  = d;
        point = p;
        sign  = s;
        repeat (26) @(negedge sys_clk);
        for (int i = 0; i < 6; i++) begin
            e.digit = i;
            e.seg   = exp_seg(d, p, s, i);
            sb.push_back(e);
        end
        wait_sb();
    endtask

    initial begin : stim
        logic [5:0]  prev_sel;
        logic [23:0] prev_disp;
        logic [23:0] hist[$];
        logic [19:0] d;
        int          cnt;
        bit          found;

        sys_rst_n = 1'b0;
        data  = 20'd123456;
        point = 6'd0;
        sign  = 1'b0;
        seg_en = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("reset_sel", {26'd0, sel}, 32'd0);
        chk("reset_seg", {24'd0, seg}, 32'hFF);
        chk("reset_disp", {8'd0, dut.disp_bcd}, 32'd0);
        sys_rst_n = 1'b1;

        // Basic value and digit rotation/dwell
        scenario(20'd123456, 6'd0, 1'b0);
        cnt = 0;
        prev_sel = sel;
        while (sel == prev_sel && cnt < 20) begin @(negedge sys_clk); cnt++; end
        for (int k = 0; k < 6; k++) begin
            prev_sel = sel;
            cnt = 0;
            while (sel == prev_sel && cnt < 50) begin @(negedge sys_clk); cnt++; end
            chk("dwell", cnt, 4);
            chk("sel_rotate", {26'd0, sel},
                {26'd0, (prev_sel == 6'h20) ? 6'h01 : (prev_sel << 1)});
        end

        // Directed boundary cases
        scenario(20'd0, 6'd0, 1'b0);
        scenario(20'd42, 6'd0, 1'b1);
        scenario(20'd5, 6'b000100, 1'b0);
        scenario(20'd5, 6'b000100, 1'b1);
        scenario(20'hFFFFF, 6'd0, 1'b0);
        scenario(20'd999999, 6'd0, 1'b1);
        scenario(20'd7, 6'b100001, 1'b0);

        // Randomized values, points and sign
        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 2))
                0:       d = 20'($urandom_range(0, 999));
                1:       d = 20'($urandom_range(0, 999999));
                default: d = 20'($urandom);
            endcase
            scenario(d, ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
                     1'($urandom_range(0, 1)));
        end

        // Conversion latency: display register updates 22 cycles after the change
        @(negedge sys_clk);
        data = 20'd314159;
        repeat (21) @(posedge sys_clk);
        #1 chk("latency_21", {8'd0, dut.disp_bcd}, {8'd0, to_bcd(d)});
        @(posedge sys_clk);
        #1 chk("latency_22", {8'd0, dut.disp_bcd}, {8'd0, to_bcd(20'd314159)});

        // Data changing every cycle: display only ever shows complete conversions
        hist.delete();
        hist.push_back(to_bcd(20'd314159));
        prev_disp = dut.disp_bcd;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (i < 30) begin
                d = 20'($urandom);
                data = d;
                hist.push_back(to_bcd(d));
            end
            @(posedge sys_clk);
            #1;
            if (dut.disp_bcd != prev_disp) begin
                found = 0;
                foreach (hist[j]) if (hist[j] == dut.disp_bcd) found = 1;
                chk("burst_no_partial", {31'd0, found}, 32'd1);
                prev_disp = dut.disp_bcd;
            end
        end
        chk("burst_final", {8'd0, dut.disp_bcd}, {8'd0, to_bcd(d)});
        scenario(d, 6'd0, 1'b0);

        // seg_en low blanks next cycle; conversion keeps running
        @(negedge sys_clk);
        seg_en = 1'b0;
        @(posedge sys_clk);
        #1 chk("disable_sel", {26'd0, sel}, 32'd0);
        chk("disable_seg", {24'd0, seg}, 32'hFF);
        @(negedge sys_clk);
        data = 20'd8080;
        repeat (30) @(negedge sys_clk);
        chk("disabled_conv", {8'd0, dut.disp_bcd}, {8'd0, to_bcd(20'd8080)});
        chk("disabled_sel_hold", {26'd0, sel}, 32'd0);
        seg_en = 1'b1;
        @(negedge sys_clk);
        chk("reenable_onehot", {31'd0, $onehot(sel)}, 32'd1);
        scenario(20'd8080, 6'd0, 1'b0);

        // Asynchronous reset in the middle of SHIFT
        @(negedge sys_clk);
        data = 20'd271828;
        repeat (5) @(posedge sys_clk);
        #3 chk("pre_reset_onehot", {31'd0, $onehot(sel)}, 32'd1);
        sys_rst_n = 1'b0;
        #1 chk("async_reset_sel", {26'd0, sel}, 32'd0);
        chk("async_reset_seg", {24'd0, seg}, 32'hFF);
        chk("async_reset_disp", {8'd0, dut.disp_bcd}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        scenario(20'd271828, 6'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
